rc5_encrypt_core: RTL
=====================

Name: rc5_encrypt_core

Overview:
- Iterative RC5-32/12/16 block encryptor, one round per clock.
- Counterpart of the existing RC5 decryption core: same 26-word expanded key table S[0..25], same word order (A = din[63:32], B = din[31:0]).
- Sits on the transmit side of the datapath; its ciphertext feeds the decryption core directly.
- Valid/ready handshake on input; valid/ack handshake with held output.

Parameters:
ROUNDS, 12, number of rounds; legal range 1..12 (table holds 2*12+2 words).

Ports:
clk  in  1  rising-edge clock
clr  in  1  asynchronous, active-high reset
din_valid  in  1  plaintext block offered
din_ready  out  1  core can accept a block this cycle
din  in  64  plaintext {A,B}
dout_valid  out  1  ciphertext available, held until acknowledged
dout_ack  in  1  consumer takes ciphertext
dout  out  64  ciphertext {A,B}
busy  out  1  encryption in progress (ROUND state)

Behaviour:
- Key table S, fixed constants (hex):
  - S[0]..S[5] = 0, 0, 46F8E8C5, 460C6085, 70F83B8A, 284B8303
  - S[6]..S[11] = 513E1454, F621ED22, 3125065D, 11A83A5D, D427686B, 713AD82D
  - S[12]..S[17] = 4B792F99, 2799A4DD, A7901C49, DEDE871A, 36C03196, A7EFC249
  - S[18]..S[23] = 61A78BB8, 3B0A1D2B, 4DBFCA76, AE162167, 30D76B0A, 43192304
  - S[24]..S[25] = F6CC1431, 65046380
- Arithmetic: all adds modulo 2^32. "<<<" is a left rotate by the low 5 bits of the named operand; a shift amount of 0 means no change.
- States: IDLE, ROUND, DONE.
- Reset (clr=1, any time, asynchronous):
  - state=IDLE, round counter i=1, A=B=0.
  - din_ready=1 once clr deasserts; dout_valid=0, busy=0, dout=0.
  - An in-flight block is discarded; no partial result appears.
- IDLE:
  - din_ready=1.
  - On an edge with din_valid=1: A <= din[63:32]+S[0], B <= din[31:0]+S[1], i <= 1, state <= ROUND.
  - din_valid=0: nothing changes.
- ROUND:
  - din_ready=0, busy=1.
  - Each edge computes one round:
    - A' = ((A^B) <<< B) + S[2i]
    - B' = ((B^A') <<< A') + S[2i+1]
    - B' uses the new A' combinationally within the same cycle.
  - If i==ROUNDS: state <= DONE, i <= 1. Otherwise i <= i+1.
- DONE:
  - dout_valid=1, dout={A,B} held stable, din_ready=0.
  - On an edge with dout_ack=1: state <= IDLE.
  - dout keeps its last value after leaving DONE until the next block loads.
- Latency: dout_valid rises ROUNDS+1 edges after the accept edge (13 for the default).
- Throughput: one block per ROUNDS+2 cycles minimum, with dout_ack tied high.
- Simultaneous / out-of-state events:
  - din_valid while not IDLE: ignored. The producer must hold it; no buffering.
  - dout_ack outside DONE: ignored.
  - din_valid and dout_ack on the same DONE edge: only the ack acts. The new block is taken on the following IDLE cycle.
- Width rule: the round index i is 4 bits; S address = {i,0} / {i,1}.

Test Plan:
1. Reset mid-ROUND (assert clr 5 cycles after accept) -> dout_valid=0, busy=0, din_ready=1 immediately after release; next block encrypts correctly.
2. ROUNDS=1, din=0 -> dout_valid after 2 edges, dout=64'h46F8E8C5_2529792D.
3. ROUNDS=12, din=64'h0123456789ABCDEF:
   - dout_valid rises exactly 13 edges after accept.
   - Feeding dout to the decryption core returns 64'h0123456789ABCDEF.
4. Round-trip of 1000 random blocks through the encryption then decryption core -> all match; no block is ever output twice.
5. Hold dout_ack=0 for 20 cycles in DONE with din_valid=1 -> dout is stable, din_ready=0. Pulse ack -> IDLE next edge, then the pending block is accepted.
6. Back-to-back with dout_ack tied 1 and din_valid tied 1 -> one accept every 14 cycles; busy high 12 cycles per block.

Source files
------------

// File: rtl/rc5_encrypt_core_if.sv
// Handshake bundle for the RC5 encryptor: valid/ready plaintext in, valid/ack ciphertext out.
interface rc5_encrypt_core_if;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] din;
    logic        dout_valid;
    logic        dout_ack;
    logic [63:0] dout;
    logic        busy;

    modport master (
        output din_valid, din, dout_ack,
        input  din_ready, dout_valid, dout, busy
    );

    modport slave (
        input  din_valid, din, dout_ack,
        output din_ready, dout_valid, dout, busy
    );
endinterface

// File: rtl/rc5_encrypt_core.sv
// Iterative RC5-32/ROUNDS/16 block encryptor, one round per clock, fixed expanded key table.
//
//   state | meaning
//   IDLE  | ready for a plaintext block
//   ROUND | one round per edge, round index i_q = 1..ROUNDS
//   DONE  | ciphertext held on dout until dout_ack
module rc5_encrypt_core #(
    parameter int ROUNDS = 12
) (
    input  logic clk,
    input  logic clr,
    rc5_encrypt_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  i_q, i_d;
    logic [31:0] a_rnd, b_rnd;

    function automatic logic [31:0] skey(input logic [4:0] idx);
        case (idx)
            5'd0:  skey = 32'h00000000;
            5'd1:  skey = 32'h00000000;
            5'd2:  skey = 32'h46F8E8C5;
            5'd3:  skey = 32'h460C6085;
            5'd4:  skey = 32'h70F83B8A;
            5'd5:  skey = 32'h284B8303;
            5'd6:  skey = 32'h513E1454;
            5'd7:  skey = 32'hF621ED22;
            5'd8:  skey = 32'h3125065D;
            5'd9:  skey = 32'h11A83A5D;
            5'd10: skey = 32'hD427686B;
            5'd11: skey = 32'h713AD82D;
            5'd12: skey = 32'h4B792F99;
            5'd13: skey = 32'h2799A4DD;
            5'd14: skey = 32'hA7901C49;
            5'd15: skey = 32'hDEDE871A;
            5'd16: skey = 32'h36C03196;
            5'd17: skey = 32'hA7EFC249;
            5'd18: skey = 32'h61A78BB8;
            5'd19: skey = 32'h3B0A1D2B;
            5'd20: skey = 32'h4DBFCA76;
            5'd21: skey = 32'hAE162167;
            5'd22: skey = 32'h30D76B0A;
            5'd23: skey = 32'h43192304;
            5'd24: skey = 32'hF6CC1431;
            5'd25: skey = 32'h65046380;
            default: skey = 32'h00000000;
        endcase
    endfunction

    // Upper half of the doubled word shifted left is the rotate; sh = 0 passes x through.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] t;
        t = {x, x} << sh;
        rotl = t[63:32];
    endfunction

    // B half of the round consumes the freshly computed A half in the same cycle.
    assign a_rnd = rotl(a_q ^ b_q, b_q[4:0]) + skey({i_q, 1'b0});
    assign b_rnd = rotl(b_q ^ a_rnd, a_rnd[4:0]) + skey({i_q, 1'b1});

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            i_q     <= 4'd1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        case (state_q)
            IDLE: begin
                if (bus.din_valid) begin
                    a_d     = bus.din[63:32] + skey(5'd0);
                    b_d     = bus.din[31:0]  + skey(5'd1);
                    i_d     = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                a_d = a_rnd;
                b_d = b_rnd;
                if (i_q == LAST_ROUND) begin
                    state_d = DONE;
                    i_d     = 4'd1;
                end else begin
                    i_d = i_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.dout_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // dout tracks the working registers, so it holds the result until the next load.
    assign bus.din_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q == ROUND);
    assign bus.dout_valid = (state_q == DONE);
    assign bus.dout       = {a_q, b_q};
endmodule
